// File: rtl/reg_file_mp.sv
// Multi-ported register file with a per-entry busy scoreboard.
// Two registered read ports, one write port with write-before-read bypass, and an issue port.
module reg_file_mp #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              busy_a,
   output logic              busy_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic              wr_ok;
   logic              iss_ok;
   logic              zero_a;
   logic              zero_b;
   logic [DATA_W-1:0] data_a_nxt;
   logic [DATA_W-1:0] data_b_nxt;

   // Address 0 is inert when hardwired: no writes, no issue, no bypass.
   assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr   == '0));
   assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr  == '0));
   assign zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
   assign zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);

   // Clear from writeback first, then set from issue so issue wins on a collision.
   always_comb begin
      busy_nxt = busy;
      if (wr_ok)
         busy_nxt[wr_addr] = 1'b0;
      if (iss_ok)
         busy_nxt[iss_addr] = 1'b1;
   end

   always_comb begin
      data_a_nxt = mem[rd_addr_a];
      data_b_nxt = mem[rd_addr_b];
      if (wr_ok && (wr_addr == rd_addr_a))
         data_a_nxt = wr_data;
      if (wr_ok && (wr_addr == rd_addr_b))
         data_b_nxt = wr_data;
      if (zero_a)
         data_a_nxt = '0;
      if (zero_b)
         data_b_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         busy      <= '0;
         rd_data_a <= '0;
         rd_data_b <= '0;
         busy_a    <= 1'b0;
         busy_b    <= 1'b0;
      end else begin
         if (wr_ok)
            mem[wr_addr] <= wr_data;
         busy <= busy_nxt;
         if (rd_en) begin
            rd_data_a <= data_a_nxt;
            rd_data_b <= data_b_nxt;
            busy_a    <= busy_nxt[rd_addr_a];
            busy_b    <= busy_nxt[rd_addr_b];
         end
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry after every clock edge.
module tb_reg_file_mp;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              busy_a;
   logic              busy_b;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_addr;

   typedef struct {
      int                vec;
      logic [DATA_W-1:0] data_a;
      logic [DATA_W-1:0] data_b;
      logic              busy_a;
      logic              busy_b;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   vec_no = 0;

   reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int vec,
                               input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL vec%0d %s: got 0x%0h, expected 0x%0h", vec, name, act, req);
      end
   endtask

   // Every edge produces an observable output state, so every edge consumes one expectation.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_output("rd_data_a", e.vec, rd_data_a, e.data_a);
         check_output("rd_data_b", e.vec, rd_data_b, e.data_b);
         check_output("busy_a", e.vec, {{(DATA_W-1){1'b0}}, busy_a}, {{(DATA_W-1){1'b0}}, e.busy_a});
         check_output("busy_b", e.vec, {{(DATA_W-1){1'b0}}, busy_b}, {{(DATA_W-1){1'b0}}, e.busy_b});
      end
   end

   task automatic apply_stimulus(
      input logic rst, input logic we, input int wa, input logic [DATA_W-1:0] wd,
      input logic ie, input int ia, input logic re, input int ra, input int rb,
      input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb,
      input logic eba, input logic ebb);
      exp_t e;
      @(negedge clk);
      rst_n     = rst;
      wr_en     = we;
      wr_addr   = ADDR_W'(wa);
      wr_data   = wd;
      iss_en    = ie;
      iss_addr  = ADDR_W'(ia);
      rd_en     = re;
      rd_addr_a = ADDR_W'(ra);
      rd_addr_b = ADDR_W'(rb);
      vec_no++;
      e.vec    = vec_no;
      e.data_a = ea;
      e.data_b = eb;
      e.busy_a = eba;
      e.busy_b = ebb;
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DATA_W-1:0] v5;
      logic [DATA_W-1:0] v31;
      v5  = 64'h0123_4567_89AB_CDEF;
      v31 = 64'hAAAA_5555_F00D_C0DE;
      rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
      rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;

      //             rst we wa  wd            ie ia re ra  rb   exp_a   exp_b   ba bb
      apply_stimulus(0, 0, 0,  64'h0,        0, 0, 0, 0,  0,   64'h0,  64'h0,  0, 0);
      apply_stimulus(0, 1, 5,  64'h77,       1, 5, 1, 5,  5,   64'h0,  64'h0,  0, 0);
      apply_stimulus(1, 0, 0,  64'h0,        0, 0, 1, 7,  31,  64'h0,  64'h0,  0, 0);
      apply_stimulus(1, 1, 5,  v5,           0, 0, 0, 0,  0,   64'h0,  64'h0,  0, 0);
      apply_stimulus(1, 0, 0,  64'h0,        0, 0, 1, 5,  7,   v5,     64'h0,  0, 0);
      apply_stimulus(1, 1, 6,  64'h1111,     0, 0, 0, 0,  0,   v5,     64'h0,  0, 0);
      apply_stimulus(1, 1, 9,  64'hDEAD,     0, 0, 1, 9,  5,   64'hDEAD, v5,   0, 0);
      apply_stimulus(1, 1, 0,  64'hFFFF,     1, 0, 1, 0,  0,   64'h0,  64'h0,  0, 0);
      apply_stimulus(1, 0, 0,  64'h0,        0, 0, 1, 0,  6,   64'h0,  64'h1111, 0, 0);
      apply_stimulus(1, 0, 0,  64'h0,        1, 3, 1, 9,  3,   64'hDEAD, 64'h0, 0, 1);
      apply_stimulus(1, 1, 3,  64'h33,       1, 3, 1, 3,  3,   64'h33, 64'h33, 1, 1);
      apply_stimulus(1, 1, 3,  64'h44,       0, 0, 1, 3,  3,   64'h44, 64'h44, 0, 0);
      apply_stimulus(1, 1, 8,  64'h88,       1, 7, 1, 7,  8,   64'h0,  64'h88, 1, 0);
      apply_stimulus(1, 0, 0,  64'h0,        1, 8, 0, 0,  0,   64'h0,  64'h88, 1, 0);
      apply_stimulus(1, 0, 0,  64'h0,        0, 0, 1, 8,  7,   64'h88, 64'h0,  1, 1);
      apply_stimulus(1, 1, 31, v31,          0, 0, 1, 31, 1,   v31,    64'h0,  0, 0);
      apply_stimulus(1, 1, 12, 64'h55,       0, 0, 0, 0,  0,   v31,    64'h0,  0, 0);
      apply_stimulus(1, 0, 0,  64'h0,        1, 12, 1, 12, 31, 64'h55, v31,    1, 0);
      apply_stimulus(0, 1, 12, 64'hAA,       0, 0, 1, 12, 12,  64'h0,  64'h0,  0, 0);
      apply_stimulus(1, 0, 0,  64'h0,        0, 0, 1, 12, 3,   64'h0,  64'h0,  0, 0);
      apply_stimulus(1, 0, 0,  64'h0,        0, 0, 1, 8,  31,  64'h0,  64'h0,  0, 0);

      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
